// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the key conditioning front end: channel FSM
// encoding and the role of each key bit.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_CHK_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_CHK_RELEASE = 2'd3
    } chan_state_e;

    localparam int KEY_BIT1  = 0;
    localparam int KEY_BIT0  = 1;
    localparam int KEY_START = 2;
    localparam int NUM_KEYS  = 3;

    // A channel reports the key as held once the press has been accepted,
    // and keeps doing so until a release has been accepted.
    function automatic logic is_held(input chan_state_e st);
        return (st == ST_PRESSED) || (st == ST_CHK_RELEASE);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key input: synchronizer, stability counter and press/release FSM.
// level_n and press_evt describe the state taken at the coming clock edge.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level_n,
    output logic press_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    chan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;

    // NOTE: synchronizer flops reset to 1 so a key that is already held when
    // reset lifts looks like a fresh press and must be qualified again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    assign sync_n  = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        unique case (state_q)
            ST_RELEASED: begin
                if (!sync_n) begin
                    state_d = ST_CHK_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_CHK_PRESS: begin
                if (sync_n) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_PRESSED;
                    cnt_d     = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PRESSED: begin
                if (sync_n) begin
                    state_d = ST_CHK_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_CHK_RELEASE: begin
                if (!sync_n) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_n = ~is_held(state_d);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Turns three bouncing active-low keys into registered bit strobes, a
// conflict pulse and a debounced active-low start level.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_n,
    output logic       button0,
    output logic       button1,
    output logic       start,
    output logic       conflict
);

    logic [NUM_KEYS-1:0] level_n;
    logic [NUM_KEYS-1:0] press_evt;
    logic                both_evt;
    logic                button0_d, button1_d, conflict_d;
    logic                button0_q, button1_q, conflict_q, start_q;
    logic                unused_chan_outputs;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_n     (key_n[i]),
            .level_n   (level_n[i]),
            .press_evt (press_evt[i])
        );
    end

    // The start key only needs its level; the bit keys only their press events.
    assign unused_chan_outputs = ^{press_evt[KEY_START], level_n[KEY_BIT1], level_n[KEY_BIT0]};

    // A same-cycle pair of bit presses is ambiguous, so neither bit is entered.
    always_comb begin
        both_evt   = press_evt[KEY_BIT1] & press_evt[KEY_BIT0];
        button0_d  = press_evt[KEY_BIT1] & ~both_evt;
        button1_d  = press_evt[KEY_BIT0] & ~both_evt;
        conflict_d = both_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button0_q  <= 1'b0;
            button1_q  <= 1'b0;
            conflict_q <= 1'b0;
            start_q    <= 1'b1;
        end else begin
            button0_q  <= button0_d;
            button1_q  <= button1_d;
            conflict_q <= conflict_d;
            start_q    <= level_n[KEY_START];
        end
    end

    assign button0  = button0_q;
    assign button1  = button1_q;
    assign conflict = conflict_q;
    assign start    = start_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a short debounce window.
module tb_button_conditioner;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] key_n;
    logic       button0, button1, start, conflict;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
        .SYNC_STAGES     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .button0  (button0),
        .button1  (button1),
        .start    (start),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] key_n;
        logic       b0, b1, st, cf;
    } vec_t;

    typedef struct {
        int n0, n1, nc;
        int f0, f1, fc, fs;
    } obs_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [2:0] k, input logic b0, input logic b1,
                                input logic st, input logic cf);
        vec_t v;
        v.key_n = k;
        v.b0 = b0;
        v.b1 = b1;
        v.st = st;
        v.cf = cf;
        vecs.push_back(v);
    endfunction

    task automatic watch(input int cycles, output obs_t o);
        o = '{default: 0};
        o.f0 = -1; o.f1 = -1; o.fc = -1; o.fs = -1;
        for (int c = 1; c <= cycles; c++) begin
            tick();
            if (button0)  begin o.n0++; if (o.f0 < 0) o.f0 = c; end
            if (button1)  begin o.n1++; if (o.f1 < 0) o.f1 = c; end
            if (conflict) begin o.nc++; if (o.fc < 0) o.fc = c; end
            if (!start && o.fs < 0) o.fs = c;
        end
    endtask

    initial begin
        obs_t o;

        // Single press on the bit-1 key, then release.
        for (int k = 1; k <= 10; k++) add(3'b110, k == 7, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) add(3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        // Both bit keys on the same edge.
        for (int k = 1; k <= 10; k++) add(3'b100, 1'b0, 1'b0, 1'b1, k == 7);
        for (int k = 1; k <= 10; k++) add(3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        // Start key press and release.
        for (int k = 1; k <= 10; k++) add(3'b011, 1'b0, 1'b0, k < 7, 1'b0);
        for (int k = 1; k <= 10; k++) add(3'b111, 1'b0, 1'b0, k >= 7, 1'b0);

        key_n = 3'b111;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset button0", button0, 0);
        check("reset button1", button1, 0);
        check("reset start", start, 1);
        check("reset conflict", conflict, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        foreach (vecs[i]) begin
            key_n = vecs[i].key_n;
            tick();
            check($sformatf("vec%0d button0", i), button0, vecs[i].b0);
            check($sformatf("vec%0d button1", i), button1, vecs[i].b1);
            check($sformatf("vec%0d start", i), start, vecs[i].st);
            check($sformatf("vec%0d conflict", i), conflict, vecs[i].cf);
        end

        // Bouncing bit-0 key: 2-cycle pulses never survive the window.
        for (int p = 0; p < 5; p++) begin
            for (int h = 0; h < 4; h++) begin
                key_n[1] = (h >= 2);
                tick();
                check($sformatf("bounce p%0d h%0d button1", p, h), button1, 0);
            end
        end
        key_n[1] = 1'b0;
        watch(15, o);
        check("settle button1 count", o.n1, 1);
        check("settle button1 cycle", o.f1, 7);
        check("settle button0 count", o.n0, 0);
        key_n[1] = 1'b1;
        watch(12, o);
        check("settle release button1", o.n1, 0);

        // Long hold gives one strobe; a new press after release gives another.
        key_n[0] = 1'b0;
        watch(100, o);
        check("hold button0 count", o.n0, 1);
        check("hold button0 cycle", o.f0, 7);
        key_n[0] = 1'b1;
        watch(12, o);
        check("release button0 count", o.n0, 0);
        key_n[0] = 1'b0;
        watch(15, o);
        check("repress button0 count", o.n0, 1);
        check("repress button0 cycle", o.f0, 7);

        // Bit-0 key accepted while bit-1 key is still held: allowed, no conflict.
        key_n[1] = 1'b0;
        watch(15, o);
        check("overlap button1 count", o.n1, 1);
        check("overlap button0 count", o.n0, 0);
        check("overlap conflict count", o.nc, 0);
        key_n = 3'b111;
        watch(12, o);

        // Reset in the middle of qualifying a press, with start held.
        key_n = 3'b011;
        repeat (10) tick();
        check("pre-reset start", start, 0);
        key_n = 3'b010;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("async reset start", start, 1);
        check("async reset button0", button0, 0);
        check("async reset button1", button1, 0);
        check("async reset conflict", conflict, 0);
        repeat (3) tick();
        check("in reset button0", button0, 0);
        rst_n = 1'b1;
        watch(20, o);
        check("post-reset button0 count", o.n0, 1);
        check("post-reset button0 cycle", o.f0, 7);
        check("post-reset start cycle", o.fs, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
